// File: rtl/imm_gen_pipe.sv
// -----------------------------------------------------------------------------
// imm_gen_pipe
//   Registered immediate generator that sits between fetch and execute.
//   Each accepted instruction is decoded at capture time into an immediate
//   (sign-extended to XLEN), a 3-bit format code and the caller's opaque tag.
//   A two-entry buffer (output register + skid register) absorbs downstream
//   stalls. Order is strictly FIFO, and no entry is dropped or duplicated.
//
//   Optional feature macro: IMM_GEN_ZIMM_EN
//     defined   : SYSTEM opcode with funct3[2]=1 (CSRR*I) -> type 6, imm =
//                 zext(instr[19:15]); other SYSTEM -> type I.
//     undefined : every SYSTEM opcode -> type I. Type 6 is never produced.
//
// Parameters
//   XLEN   immediate/output width (32 or 64)
//   TAG_W  width of the passthrough tag
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   flush      synchronous flush; discards every buffered entry
//   in_valid   upstream instruction present
//   in_ready   buffer can accept (decoded from registered state only)
//   in_instr   32-bit instruction word
//   in_tag     passthrough tag
//   out_valid  result present
//   out_ready  downstream accepts
//   out_imm    immediate
//   out_type   0 R, 1 I, 2 S, 3 B, 4 U, 5 J, 6 Z, 7 ILLEGAL
//   out_tag    tag of the presented entry
// -----------------------------------------------------------------------------
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_type,
  output logic [TAG_W-1:0] out_tag
);

  localparam logic [2:0] T_R   = 3'd0;
  localparam logic [2:0] T_I   = 3'd1;
  localparam logic [2:0] T_S   = 3'd2;
  localparam logic [2:0] T_B   = 3'd3;
  localparam logic [2:0] T_U   = 3'd4;
  localparam logic [2:0] T_J   = 3'd5;
  localparam logic [2:0] T_Z   = 3'd6;
  localparam logic [2:0] T_ILL = 3'd7;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  state_t             state_r;
  state_t             state_nxt_s;
  logic               in_ready_r;
  logic               out_valid_r;
  logic               in_fire_s;
  logic               out_fire_s;
  logic               load_out_in_s;
  logic               load_out_skid_s;
  logic               load_skid_s;
  logic [XLEN+2:0]    dec_s;

  logic [XLEN-1:0]    out_imm_r;
  logic [2:0]         out_type_r;
  logic [TAG_W-1:0]   out_tag_r;
  logic [XLEN-1:0]    skid_imm_r;
  logic [2:0]         skid_type_r;
  logic [TAG_W-1:0]   skid_tag_r;

  // Decode one instruction word into {format code, immediate}.
  function automatic logic [XLEN+2:0] decode(input logic [31:0] instr);
    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] imm_s;
    logic [XLEN-1:0] imm_b;
    logic [XLEN-1:0] imm_u;
    logic [XLEN-1:0] imm_j;
    logic [XLEN-1:0] imm;
    logic [2:0]      typ;
    imm_i = {{(XLEN-12){instr[31]}}, instr[31:20]};
    imm_s = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
    imm_b = {{(XLEN-13){instr[31]}}, instr[31], instr[7], instr[30:25],
             instr[11:8], 1'b0};
    imm_u = {{(XLEN-32){instr[31]}}, instr[31:12], 12'b0};
    imm_j = {{(XLEN-21){instr[31]}}, instr[31], instr[19:12], instr[20],
             instr[30:21], 1'b0};
    typ = T_ILL;
    imm = {XLEN{1'b0}};
    case (instr[6:0])
      7'b0010011, 7'b0000011, 7'b1100111: begin
        typ = T_I;
        imm = imm_i;
      end
      // OP-IMM-32 only exists on RV64.
      7'b0011011: begin
        if (XLEN == 32'sd64) begin
          typ = T_I;
          imm = imm_i;
        end else begin
          typ = T_ILL;
          imm = {XLEN{1'b0}};
        end
      end
      7'b0100011: begin
        typ = T_S;
        imm = imm_s;
      end
      7'b1100011: begin
        typ = T_B;
        imm = imm_b;
      end
      7'b0110111, 7'b0010111: begin
        typ = T_U;
        imm = imm_u;
      end
      7'b1101111: begin
        typ = T_J;
        imm = imm_j;
      end
      7'b0110011, 7'b0111011: begin
        typ = T_R;
        imm = {XLEN{1'b0}};
      end
      7'b1110011: begin
`ifdef IMM_GEN_ZIMM_EN
        // funct3[2] selects the CSR immediate forms (CSRRWI/CSRRSI/CSRRCI).
        if (instr[14]) begin
          typ = T_Z;
          imm = {{(XLEN-5){1'b0}}, instr[19:15]};
        end else begin
          typ = T_I;
          imm = imm_i;
        end
`else
        typ = T_I;
        imm = imm_i;
`endif
      end
      default: begin
        typ = T_ILL;
        imm = {XLEN{1'b0}};
      end
    endcase
    return {typ, imm};
  endfunction

  assign dec_s      = decode(in_instr);
  assign in_fire_s  = in_valid & in_ready_r;
  assign out_fire_s = out_valid_r & out_ready;

  // State register plus registered handshake flags derived from next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_EMPTY;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      in_ready_r  <= (state_nxt_s != ST_TWO);
      out_valid_r <= (state_nxt_s != ST_EMPTY);
    end
  end

  // Next-state and buffer load selection; flush overrides every transition.
  always_comb begin
    state_nxt_s     = state_r;
    load_out_in_s   = 1'b0;
    load_out_skid_s = 1'b0;
    load_skid_s     = 1'b0;
    if (flush) begin
      state_nxt_s = ST_EMPTY;
    end else begin
      case (state_r)
        ST_EMPTY: begin
          if (in_fire_s) begin
            state_nxt_s   = ST_ONE;
            load_out_in_s = 1'b1;
          end else begin
            state_nxt_s = ST_EMPTY;
          end
        end
        ST_ONE: begin
          if (in_fire_s && !out_fire_s) begin
            state_nxt_s = ST_TWO;
            load_skid_s = 1'b1;
          end else if (in_fire_s && out_fire_s) begin
            state_nxt_s   = ST_ONE;
            load_out_in_s = 1'b1;
          end else if (out_fire_s) begin
            state_nxt_s = ST_EMPTY;
          end else begin
            state_nxt_s = ST_ONE;
          end
        end
        ST_TWO: begin
          // in_ready is low here, so only the drain transition exists.
          if (out_fire_s) begin
            state_nxt_s     = ST_ONE;
            load_out_skid_s = 1'b1;
          end else begin
            state_nxt_s = ST_TWO;
          end
        end
        default: begin
          state_nxt_s = ST_EMPTY;
        end
      endcase
    end
  end

  // Output and skid registers; contents only change on a load, so a stalled
  // output stays frozen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_imm_r   <= {XLEN{1'b0}};
      out_type_r  <= 3'd0;
      out_tag_r   <= {TAG_W{1'b0}};
      skid_imm_r  <= {XLEN{1'b0}};
      skid_type_r <= 3'd0;
      skid_tag_r  <= {TAG_W{1'b0}};
    end else begin
      if (load_out_in_s) begin
        out_imm_r  <= dec_s[XLEN-1:0];
        out_type_r <= dec_s[XLEN+2:XLEN];
        out_tag_r  <= in_tag;
      end else if (load_out_skid_s) begin
        out_imm_r  <= skid_imm_r;
        out_type_r <= skid_type_r;
        out_tag_r  <= skid_tag_r;
      end
      if (load_skid_s) begin
        skid_imm_r  <= dec_s[XLEN-1:0];
        skid_type_r <= dec_s[XLEN+2:XLEN];
        skid_tag_r  <= in_tag;
      end
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_imm   = out_imm_r;
  assign out_type  = out_type_r;
  assign out_tag   = out_tag_r;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// -----------------------------------------------------------------------------
// tb_imm_gen_pipe
//   Drives one stimulus stream into an XLEN=32 and an XLEN=64 instance of
//   imm_gen_pipe. Expected results are pushed into a queue when an input is
//   accepted. A monitor on the falling edge compares the queue head against
//   both instances and pops it when the consumer accepts.
// -----------------------------------------------------------------------------
module tb_imm_gen_pipe;

  typedef struct {
    logic [31:0] imm32;
    logic [2:0]  t32;
    logic [63:0] imm64;
    logic [2:0]  t64;
    logic [4:0]  tag;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_instr = 32'd0;
  logic [4:0]  in_tag = 5'd0;
  logic        out_ready = 1'b0;

  logic        in_ready32, out_valid32, in_ready64, out_valid64;
  logic [31:0] out_imm32;
  logic [63:0] out_imm64;
  logic [2:0]  out_type32, out_type64;
  logic [4:0]  out_tag32, out_tag64;

  int   checks = 0;
  int   errors = 0;
  bit   rand_ready = 1'b0;
  exp_t q[$];

  imm_gen_pipe #(.XLEN(32), .TAG_W(5)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready32), .in_instr(in_instr), .in_tag(in_tag),
    .out_valid(out_valid32), .out_ready(out_ready),
    .out_imm(out_imm32), .out_type(out_type32), .out_tag(out_tag32)
  );

  imm_gen_pipe #(.XLEN(64), .TAG_W(5)) u_dut64 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready64), .in_instr(in_instr), .in_tag(in_tag),
    .out_valid(out_valid64), .out_ready(out_ready),
    .out_imm(out_imm64), .out_type(out_type64), .out_tag(out_tag64)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h @%0t", name, act, exp, $time);
    end
  endtask

  // Reference decode: value is built arithmetically from the instruction
  // fields, with bit 31 carrying a negative weight.
  function automatic void ref_decode(input logic [31:0] ins, input bit is64,
                                     output logic [2:0] t, output longint v);
    longint s;
    s = ins[31] ? 64'sd1 : 64'sd0;
    t = 3'd7;
    v = 0;
    case (ins[6:0])
      7'h13, 7'h03, 7'h67: begin
        t = 3'd1; v = -s * 2048 + longint'(ins[30:20]);
      end
      7'h1b: begin
        if (is64) begin
          t = 3'd1; v = -s * 2048 + longint'(ins[30:20]);
        end else begin
          t = 3'd7; v = 0;
        end
      end
      7'h23: begin
        t = 3'd2; v = -s * 2048 + longint'(ins[30:25]) * 32 + longint'(ins[11:7]);
      end
      7'h63: begin
        t = 3'd3;
        v = -s * 4096 + longint'(ins[7]) * 2048 + longint'(ins[30:25]) * 32
            + longint'(ins[11:8]) * 2;
      end
      7'h37, 7'h17: begin
        t = 3'd4; v = -s * 64'sd2147483648 + longint'(ins[30:12]) * 4096;
      end
      7'h6f: begin
        t = 3'd5;
        v = -s * 1048576 + longint'(ins[19:12]) * 4096 + longint'(ins[20]) * 2048
            + longint'(ins[30:21]) * 2;
      end
      7'h33, 7'h3b: begin
        t = 3'd0; v = 0;
      end
      7'h73: begin
`ifdef IMM_GEN_ZIMM_EN
        if (ins[14]) begin
          t = 3'd6; v = longint'(ins[19:15]);
        end else begin
          t = 3'd1; v = -s * 2048 + longint'(ins[30:20]);
        end
`else
        t = 3'd1; v = -s * 2048 + longint'(ins[30:20]);
`endif
      end
      default: begin
        t = 3'd7; v = 0;
      end
    endcase
  endfunction

  function automatic exp_t model(input logic [31:0] ins, input logic [4:0] tag);
    exp_t e;
    longint v;
    logic [63:0] u;
    logic [2:0] t;
    ref_decode(ins, 1'b0, t, v);
    u = v;
    e.imm32 = u[31:0];
    e.t32 = t;
    ref_decode(ins, 1'b1, t, v);
    e.imm64 = v;
    e.t64 = t;
    e.tag = tag;
    return e;
  endfunction

  // Scoreboard monitor: check the head entry, then pop/flush/push for the
  // handshake that completes on the coming rising edge.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("in_ready32", 64'(in_ready32), 64'(q.size() < 2));
      chk("in_ready64", 64'(in_ready64), 64'(q.size() < 2));
      if (q.size() > 0) begin
        chk("out_valid32", 64'(out_valid32), 64'd1);
        chk("out_valid64", 64'(out_valid64), 64'd1);
        chk("imm32", 64'(out_imm32), 64'(q[0].imm32));
        chk("type32", 64'(out_type32), 64'(q[0].t32));
        chk("tag32", 64'(out_tag32), 64'(q[0].tag));
        chk("imm64", out_imm64, q[0].imm64);
        chk("type64", 64'(out_type64), 64'(q[0].t64));
        chk("tag64", 64'(out_tag64), 64'(q[0].tag));
        if (out_ready && !flush) void'(q.pop_front());
      end else begin
        chk("idle_valid32", 64'(out_valid32), 64'd0);
        chk("idle_valid64", 64'(out_valid64), 64'd0);
      end
      if (flush) q.delete();
      else if (in_valid && in_ready32) q.push_back(model(in_instr, in_tag));
    end
  end

  // Present one instruction and hold it until it is accepted (bounded).
  task automatic send(input logic [31:0] ins, input logic [4:0] tag);
    int n = 0;
    bit done = 1'b0;
    in_valid = 1'b1;
    in_instr = ins;
    in_tag = tag;
    while (!done && n < 50) begin
      @(negedge clk);
      done = in_ready32 && !flush;
      @(posedge clk);
      #1;
      n++;
      if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
    end
    in_valid = 1'b0;
    chk("send_accepted", 64'(done), 64'd1);
  endtask

  task automatic drain();
    int n = 0;
    out_ready = 1'b1;
    while (q.size() > 0 && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_empty", 64'(q.size()), 64'd0);
  endtask

  task automatic check_reset_values(input string tagname);
    chk({tagname, "_valid32"}, 64'(out_valid32), 64'd0);
    chk({tagname, "_imm32"}, 64'(out_imm32), 64'd0);
    chk({tagname, "_type32"}, 64'(out_type32), 64'd0);
    chk({tagname, "_tag32"}, 64'(out_tag32), 64'd0);
    chk({tagname, "_ready32"}, 64'(in_ready32), 64'd1);
    chk({tagname, "_valid64"}, 64'(out_valid64), 64'd0);
    chk({tagname, "_imm64"}, out_imm64, 64'd0);
    chk({tagname, "_ready64"}, 64'(in_ready64), 64'd1);
  endtask

  logic [31:0] dir_vec [9] = '{32'hFFB10093, 32'h00112623, 32'hFE208EE3, 32'h123450B7,
                               32'h010000EF, 32'h800000B7, 32'h0000001B, 32'h00000000,
                               32'h3002D0F3};
  logic [6:0]  ops [12] = '{7'h13, 7'h03, 7'h67, 7'h1b, 7'h23, 7'h63,
                            7'h37, 7'h17, 7'h6f, 7'h33, 7'h3b, 7'h73};

  initial begin
    logic [31:0] r;
    logic [6:0]  op;
    logic [4:0]  tag;
    tag = 5'd0;
    #2 rst_n = 1'b0;
    #1 check_reset_values("reset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Directed vectors back to back with the consumer always ready.
    out_ready = 1'b1;
    foreach (dir_vec[i]) begin
      tag++;
      send(dir_vec[i], tag);
    end
    drain();

    // Backpressure: two entries fill the buffer, the third waits.
    out_ready = 1'b0;
    send(32'hFFB10093, 5'd1);
    send(32'h00112623, 5'd2);
    in_valid = 1'b1;
    in_instr = 32'hFE208EE3;
    in_tag = 5'd3;
    repeat (3) begin
      @(negedge clk);
      chk("bp_in_ready", 64'(in_ready32), 64'd0);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    send(32'hFE208EE3, 5'd3);
    drain();

    // Flush in state TWO together with a new input.
    out_ready = 1'b0;
    send(32'h123450B7, 5'd4);
    send(32'h010000EF, 5'd5);
    in_valid = 1'b1;
    in_instr = 32'h00112623;
    in_tag = 5'd6;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("flush_valid", 64'(out_valid32), 64'd0);
    chk("flush_ready", 64'(in_ready32), 64'd1);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(32'hFFB10093, 5'd7);
    drain();

    // Asynchronous reset while in state TWO.
    out_ready = 1'b0;
    send(32'h800000B7, 5'd8);
    send(32'hFE208EE3, 5'd9);
    #2 rst_n = 1'b0;
    #1 check_reset_values("midrst");
    q.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    send(32'h00112623, 5'd10);
    drain();

    // Randomized traffic with random backpressure and occasional flushes.
    rand_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      r = $urandom();
      op = ($urandom_range(0, 7) == 0) ? r[6:0] : ops[$urandom_range(0, 11)];
      tag++;
      if ($urandom_range(0, 24) == 0) begin
        out_ready = 1'b0;
        flush = 1'b1;
        in_valid = 1'($urandom_range(0, 1));
        in_instr = {r[31:7], op};
        @(posedge clk);
        #1;
        flush = 1'b0;
        in_valid = 1'b0;
      end else begin
        send({r[31:7], op}, tag);
      end
    end
    rand_ready = 1'b0;
    drain();

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
